// File: rtl/delay_timer_pkg.sv
// delay_timer_pkg: shared definitions for the multi-channel microsecond delay timer.
//   US_PER_S      microseconds per second
//   state_e       per-channel state encoding (ST_IDLE, ST_RUN)
//   MODE_*        mode encoding sampled with start (one-shot / periodic)
//   calc_div()    clock cycles per microsecond for a given clock frequency
//   clog2_min1()  ceil(log2(value)) with a floor of 1 bit
package delay_timer_pkg;

   localparam int US_PER_S = 1000000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   function automatic int calc_div(input int clk_freq);
      return clk_freq / US_PER_S;
   endfunction

   function automatic int clog2_min1(input int value);
      int w;
      w = 0;
      for (int v = 1; v < value; v = v * 2) begin
         w = w + 1;
      end
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/delay_timer_chan.sv
// delay_timer_chan: one independent delay channel (FSM, sub-us prescaler, us counter).
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   start     start/restart pulse; latches delay_us and periodic
//   cancel    abort; wins over start and over a terminal count
//   periodic  0 = one-shot, 1 = periodic (sampled with start)
//   delay_us  interval length in microseconds (sampled with start)
//   done      registered one-cycle pulse at the end of each completed interval
//   busy      channel is counting (registered state)
module delay_timer_chan
   import delay_timer_pkg::*;
#(
   parameter int DIV   = 12,
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cancel,
   input  logic             periodic,
   input  logic [CNT_W-1:0] delay_us,
   output logic             done,
   output logic             busy
);

   localparam int               PRE_W   = clog2_min1(DIV);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

   state_e           state_r, state_s;
   logic [PRE_W-1:0] pre_r, pre_s;
   logic [CNT_W-1:0] us_r, us_s;
   logic [CNT_W-1:0] n_r, n_s;
   logic             mode_r, mode_s;
   logic             zero_r, zero_s;
   logic             done_r, done_s;
   logic [CNT_W-1:0] us_inc_s;
   logic             pre_wrap_s;
   logic             tc_s;

   // Next-state, counter and done logic for the channel.
   always_comb begin
      state_s    = state_r;
      pre_s      = pre_r;
      us_s       = us_r;
      n_s        = n_r;
      mode_s     = mode_r;
      zero_s     = 1'b0;
      // A zero-length start from the previous cycle reports completion now.
      done_s     = zero_r;
      us_inc_s   = us_r + CNT_W'(1);
      pre_wrap_s = (pre_r == PRE_MAX);
      // Terminal count: the last prescaler cycle of the N-th microsecond.
      // us_r never exceeds N-1, so us_inc_s cannot wrap.
      tc_s       = (state_r == ST_RUN) && pre_wrap_s && (us_inc_s == n_r);

      if (cancel) begin
         state_s = ST_IDLE;
         pre_s   = {PRE_W{1'b0}};
         us_s    = {CNT_W{1'b0}};
      end else begin
         done_s = zero_r | tc_s;
         if (start) begin
            // (Re)start: the interrupted interval is dropped, but a
            // coincident terminal count has already been reported above.
            n_s    = delay_us;
            mode_s = periodic;
            pre_s  = {PRE_W{1'b0}};
            us_s   = {CNT_W{1'b0}};
            if (delay_us == {CNT_W{1'b0}}) begin
               state_s = ST_IDLE;
               zero_s  = 1'b1;
            end else begin
               state_s = ST_RUN;
            end
         end else if (tc_s) begin
            pre_s = {PRE_W{1'b0}};
            us_s  = {CNT_W{1'b0}};
            if (mode_r == MODE_PERIODIC) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_IDLE;
            end
         end else begin
            case (state_r)
               ST_RUN: begin
                  if (pre_wrap_s) begin
                     pre_s = {PRE_W{1'b0}};
                     us_s  = us_inc_s;
                  end else begin
                     pre_s = pre_r + PRE_W'(1);
                  end
               end
               ST_IDLE: begin
                  state_s = ST_IDLE;
               end
               default: begin
                  state_s = ST_IDLE;
               end
            endcase
         end
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         pre_r   <= {PRE_W{1'b0}};
         us_r    <= {CNT_W{1'b0}};
         n_r     <= {CNT_W{1'b0}};
         mode_r  <= MODE_ONESHOT;
         zero_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         pre_r   <= pre_s;
         us_r    <= us_s;
         n_r     <= n_s;
         mode_r  <= mode_s;
         zero_r  <= zero_s;
         done_r  <= done_s;
      end
   end

   assign done = done_r;
   assign busy = (state_r == ST_RUN);

endmodule

// File: rtl/delay_timer_mc.sv
// delay_timer_mc: multi-channel programmable microsecond delay timer.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   start     [NUM_CH]        per-channel start/restart pulse
//   cancel    [NUM_CH]        per-channel abort
//   periodic  [NUM_CH]        per-channel mode, sampled with start
//   delay_us  [NUM_CH*CNT_W]  packed delays, channel i at [i*CNT_W +: CNT_W]
//   done      [NUM_CH]        one-cycle pulse per completed interval
//   busy      [NUM_CH]        channel is counting
module delay_timer_mc
   import delay_timer_pkg::*;
#(
   parameter int CLK_FREQ = 12000000,
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 20
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       cancel,
   input  logic [NUM_CH-1:0]       periodic,
   input  logic [NUM_CH*CNT_W-1:0] delay_us,
   output logic [NUM_CH-1:0]       done,
   output logic [NUM_CH-1:0]       busy
);

   localparam int DIV = calc_div(CLK_FREQ);

   // The prescaler only gives exact microseconds for whole-MHz clocks.
   if ((CLK_FREQ < US_PER_S) || ((CLK_FREQ % US_PER_S) != 0)) begin : g_bad_clk
      $error("delay_timer_mc: CLK_FREQ must be a non-zero multiple of 1 MHz");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      delay_timer_chan #(
         .DIV   (DIV),
         .CNT_W (CNT_W)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .start    (start[i]),
         .cancel   (cancel[i]),
         .periodic (periodic[i]),
         .delay_us (delay_us[i*CNT_W +: CNT_W]),
         .done     (done[i]),
         .busy     (busy[i])
      );
   end

endmodule

// File: tb/tb_delay_timer_mc.sv
// tb_delay_timer_mc: directed scenarios plus random traffic, checked every
// cycle against a deadline-based reference model; a second 1-channel,
// 4-bit instance covers the maximum delay.
module tb_delay_timer_mc;

   localparam int CLK_FREQ = 12000000;
   localparam int NUM_CH   = 4;
   localparam int CNT_W    = 20;
   localparam int DIV      = CLK_FREQ / 1000000;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH-1:0]       start, cancel, periodic;
   logic [NUM_CH*CNT_W-1:0] delay_us;
   logic [NUM_CH-1:0]       done, busy;

   logic       rst4, start4, cancel4, periodic4;
   logic [3:0] delay4;
   logic       done4, busy4;

   always #5 clk = ~clk;

   delay_timer_mc #(.CLK_FREQ(CLK_FREQ), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .cancel(cancel), .periodic(periodic),
      .delay_us(delay_us), .done(done), .busy(busy));

   delay_timer_mc #(.CLK_FREQ(CLK_FREQ), .NUM_CH(1), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst4), .start(start4), .cancel(cancel4), .periodic(periodic4),
      .delay_us(delay4), .done(done4), .busy(busy4));

   int total = 0;
   int bad   = 0;
   longint cyc = 0;

   // Reference model: each channel is "active until an absolute deadline".
   bit     m_act  [NUM_CH];
   bit     m_per  [NUM_CH];
   longint m_dead [NUM_CH];
   longint m_len  [NUM_CH];
   longint m_zero [NUM_CH];
   logic [NUM_CH-1:0] exp_done, exp_busy;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < NUM_CH; i++) begin
         longint n;
         n = longint'(delay_us[i*CNT_W +: CNT_W]);
         exp_done[i] = 1'b0;
         if (rst) begin
            m_act[i]  = 1'b0;
            m_zero[i] = -1;
         end else if (cancel[i]) begin
            exp_done[i] = (m_zero[i] == cyc);
            m_act[i]    = 1'b0;
         end else begin
            exp_done[i] = (m_act[i] && m_dead[i] == cyc) || (m_zero[i] == cyc);
            if (start[i]) begin
               if (n == 0) begin
                  m_act[i]  = 1'b0;
                  m_zero[i] = cyc + 1;
               end else begin
                  m_act[i]  = 1'b1;
                  m_per[i]  = periodic[i];
                  m_len[i]  = n * DIV;
                  m_dead[i] = cyc + m_len[i];
               end
            end else if (m_act[i] && m_dead[i] == cyc) begin
               if (m_per[i]) m_dead[i] = m_dead[i] + m_len[i];
               else          m_act[i]  = 1'b0;
            end
         end
         exp_busy[i] = m_act[i];
      end
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check({tag, " done"}, 64'(done), 64'(exp_done));
      check({tag, " busy"}, 64'(busy), 64'(exp_busy));
   endtask

   task automatic idle_inputs();
      start    = '0;
      cancel   = '0;
      periodic = '0;
      delay_us = '0;
      rst      = 1'b0;
   endtask

   task automatic go(input int ch, input int n, input bit per);
      start[ch]                 = 1'b1;
      periodic[ch]              = per;
      delay_us[ch*CNT_W +: CNT_W] = CNT_W'(n);
   endtask

   task automatic run(input string tag, input int cycles);
      for (int k = 0; k < cycles; k++) tick(tag);
   endtask

   initial begin
      for (int i = 0; i < NUM_CH; i++) begin
         m_act[i] = 1'b0; m_per[i] = 1'b0; m_dead[i] = -1; m_len[i] = 0; m_zero[i] = -1;
      end
      idle_inputs();
      rst4 = 1'b1; start4 = 1'b0; cancel4 = 1'b0; periodic4 = 1'b0; delay4 = 4'd0;
      rst = 1'b1;
      run("reset", 3);
      rst = 1'b0; rst4 = 1'b0;
      run("idle", 3);

      // Test 1: one-shot N=5 on ch0.
      go(0, 5, 1'b0); tick("t1 start"); idle_inputs();
      run("t1", 70);

      // Test 2: periodic N=3 on ch1, cancel at T0+100.
      go(1, 3, 1'b1); tick("t2 start"); idle_inputs();
      run("t2", 99);
      cancel[1] = 1'b1; tick("t2 cancel"); idle_inputs();
      run("t2 after", 20);

      // Test 3: ch2 N=10 restarted with N=2 at T0+50.
      go(2, 10, 1'b0); tick("t3 start"); idle_inputs();
      run("t3", 49);
      go(2, 2, 1'b0); tick("t3 restart"); idle_inputs();
      run("t3 after", 90);

      // Test 4a: zero delay on ch3 (periodic bit set, still no run).
      go(3, 0, 1'b1); tick("t4 zero"); idle_inputs();
      run("t4 zero after", 5);
      // Test 4b: start coincident with terminal count on ch0.
      go(0, 2, 1'b0); tick("t4 tc start"); idle_inputs();
      run("t4 tc", 23);
      go(0, 1, 1'b0); tick("t4 tc restart"); idle_inputs();
      run("t4 tc after", 20);
      // Test 4c: cancel coincident with terminal count on ch1.
      go(1, 2, 1'b1); tick("t4 cancel start"); idle_inputs();
      run("t4 cancel", 23);
      cancel[1] = 1'b1; tick("t4 cancel tc"); idle_inputs();
      run("t4 cancel after", 10);

      // Test 5: reset while all channels run.
      for (int i = 0; i < NUM_CH; i++) go(i, 4, 1'b1);
      tick("t5 start"); idle_inputs();
      run("t5", 20);
      rst = 1'b1; tick("t5 rst"); idle_inputs();
      run("t5 after", 100);

      // Random traffic on all channels, with rare resets.
      for (int k = 0; k < 4000; k++) begin
         idle_inputs();
         for (int i = 0; i < NUM_CH; i++) begin
            if ($urandom_range(0, 24) == 0) go(i, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 79) == 0) cancel[i] = 1'b1;
            if (!start[i]) delay_us[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 255));
         end
         if ($urandom_range(0, 599) == 0) rst = 1'b1;
         tick("rand");
      end
      idle_inputs();
      run("drain", 100);

      // Maximum delay with CNT_W=4: N=15 -> done at T0+180.
      start4 = 1'b1; delay4 = 4'd15; periodic4 = 1'b0;
      @(posedge clk); #1;
      start4 = 1'b0; delay4 = 4'd0;
      check("max busy T0", 64'(busy4), 64'd1);
      for (int k = 1; k <= 185; k++) begin
         @(posedge clk); #1;
         check("max done", 64'(done4), 64'(k == 180));
         check("max busy", 64'(busy4), 64'(k < 180));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/delay_timer_mc.md
Name: delay_timer_mc

Overview:
- Multi-channel programmable microsecond delay timer; parametrised successor to the single-shot 1 us delay used by the SW/IR interface logic.
- Each channel independently runs one-shot or periodic delays of 0..2^CNT_W-1 us, with restart and cancel.
- Fully synchronous on one clock; no trigger-edge clocking. Serves IR bit timing, key debounce and LED scan pacing.

Parameters:
- CLK_FREQ, 12000000, system clock in Hz; must be an integer multiple of 1000000 and at least 1000000.
- NUM_CH, 4, number of independent channels, 1..16.
- CNT_W, 20, width of the per-channel delay value in microseconds.

Ports:
- clk  input  1  system clock; one clock domain, all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  NUM_CH  per-channel start pulse; sampled each cycle.
- cancel  input  NUM_CH  per-channel abort.
- periodic  input  NUM_CH  mode, sampled with start: 0 = one-shot, 1 = periodic.
- delay_us  input  NUM_CH*CNT_W  packed delay values; channel i uses bits [i*CNT_W +: CNT_W], sampled with start.
- done  output  NUM_CH  one-cycle pulse at the end of each completed interval.
- busy  output  NUM_CH  channel is counting.

Behaviour:
- Reset: synchronous, active-high. While rst=1, at each clk edge: done=0, busy=0, all counters=0, latched values=0. rst mid-delay aborts silently and produces no done.
- Constant DIV = CLK_FREQ/1000000 (12 at default).
- Each channel has its own sub-us prescaler (0..DIV-1) and us counter, so timing is exact and not quantised to a shared tick.
- Per-channel states: IDLE, RUN.
- IDLE to RUN: start=1 and cancel=0 at edge T0 with delay_us=N, N>0.
  - N and the periodic bit are latched; prescaler and us counter clear.
  - busy=1 from T0.
- Terminal count: reached at edge T0 + N*DIV.
  - done=1 for exactly that cycle.
  - One-shot: busy=0 at the same edge and the state returns to IDLE.
  - Periodic: counters reload, busy stays 1, and done repeats every N*DIV cycles until cancelled.
- Zero delay: start with N=0 pulses done at edge T0+1. busy stays 0. The channel stays IDLE regardless of the periodic bit.
- Restart: start while in RUN relatches N and mode and restarts counting from T0. The interrupted interval produces no done.
  - If start coincides with terminal count, done still pulses for the completed interval and the new interval begins.
- Cancel: cancel=1 forces IDLE and busy=0 at that edge.
  - Cancel beats a terminal count in the same cycle, so no done.
  - Cancel beats start in the same cycle.
  - Cancel in IDLE has no effect.
- Width rules: us counter is CNT_W bits and the prescaler is clog2(DIV) bits (minimum 1). Maximum delay is (2^CNT_W - 1) us with no overflow; comparisons are equality against the latched N.
- delay_us changes while in RUN are ignored until the next start.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Outputs are registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package delay_timer_pkg holds:
  - US_PER_S = 1000000
  - the function computing DIV from CLK_FREQ, plus clog2
  - state encodings ST_IDLE = 1'b0, ST_RUN = 1'b1
  - mode encodings MODE_ONESHOT = 0, MODE_PERIODIC = 1
- One sub-module, delay_timer_chan: the single-channel FSM, prescaler and us counter. It is instantiated NUM_CH times in a generate loop.
- The top level only slices the packed buses and holds an elaboration-time check that CLK_FREQ is a multiple of 1 MHz.

Test Plan:
- Test 1, basic one-shot: defaults; ch0 start, N=5, periodic=0 at T0 -> done[0]=1 only at T0+60; busy[0]=1 over T0..T0+59 and 0 from T0+60; other channels silent.
- Test 2, periodic and cancel: ch1 N=3, periodic=1 -> done[1] at T0+36, +72, +108; cancel at T0+100 -> busy[1]=0 at T0+100 and no pulse at T0+108.
- Test 3, restart: ch2 N=10 at T0, restart with N=2 at T0+50 -> no done at T0+120; single done at T0+74.
- Test 4, zero delay and coincident edges:
  - N=0 start -> done at T0+1 with busy never set.
  - start coincident with terminal count -> done pulses and the new interval ends (N*DIV) later.
  - cancel coincident with terminal count -> no done.
- Test 5, reset mid-operation: all four channels running; rst=1 for one cycle -> done=0 and busy=0 at that edge, and no done ever follows. Also a max-width run: CNT_W=4, N=15 -> done at T0+180.
